tick_timekeeper: RTL

Receiving end of the divided-clock path. Takes the slow square wave produced by the clock dividers and synchronizes it into the clk domain. Detects its rising edges and turns them into one-cycle ticks. Keeps binary hours:minutes:seconds time of day and runs the alarm ring state machine that drives the alarm display and buzzer logic.

---
 rtl/timekeeper_pkg.sv | 13 +
 rtl/tick_timekeeper_edge_sync.sv | 34 +++
 rtl/tick_timekeeper.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/timekeeper_pkg.sv
// Shared constants and the alarm state type for the time-of-day keeper.
package timekeeper_pkg;

    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;
    localparam logic [4:0] HR_MAX  = 5'd23;

    typedef enum logic {
        IDLE    = 1'b0,
        RINGING = 1'b1
    } alarm_state_e;

endpackage

// File: rtl/tick_timekeeper_edge_sync.sv
// Brings an asynchronous slow square wave into the clk domain and emits a
// one-cycle pulse on each of its rising edges; falling edges are ignored.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;

    // Shift the input through the synchronizer chain; the history flop holds the previous synchronized level.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    // Synchronizer and history registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/tick_timekeeper.sv
// Time-of-day keeper: turns synchronized slow_in rising edges into seconds,
// keeps hh:mm:ss, handles set loads and runs the alarm ring state machine.
module tick_timekeeper
    import timekeeper_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int EDGES_PER_SEC = 1,
    parameter int RING_SECS     = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       slow_in,
    input  logic       set_en,
    input  logic [4:0] set_hh,
    input  logic [5:0] set_mm,
    input  logic       alarm_en,
    input  logic [4:0] alarm_hh,
    input  logic [5:0] alarm_mm,
    input  logic       stop,
    output logic [4:0] hh,
    output logic [5:0] mm,
    output logic [5:0] ss,
    output logic       sec_tick,
    output logic       set_err,
    output logic       ringing
);

    localparam int CNT_W  = $clog2(EDGES_PER_SEC + 1);
    localparam int RING_W = $clog2(RING_SECS + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(EDGES_PER_SEC - 1);
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SECS - 1);

    logic              edge_p;
    logic              set_valid;
    logic              sec_elapse;
    logic              match;
    logic [4:0]        hh_inc;
    logic [5:0]        mm_inc, ss_inc;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        hh_q, hh_d;
    logic [5:0]        mm_q, mm_d;
    logic [5:0]        ss_q, ss_d;
    logic              sec_tick_q, sec_tick_d;
    logic              set_err_q, set_err_d;
    logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
    alarm_state_e      state_q, state_d;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk     (clk),
        .rst     (rst),
        .async_in(slow_in),
        .rise    (edge_p)
    );

    // Next time value one second ahead, with the ss->mm->hh carry chain and midnight wrap.
    always_comb begin
        ss_inc = ss_q + 6'd1;
        mm_inc = mm_q;
        hh_inc = hh_q;
        if (ss_q == SEC_MAX) begin
            ss_inc = 6'd0;
            mm_inc = mm_q + 6'd1;
            if (mm_q == MIN_MAX) begin
                mm_inc = 6'd0;
                hh_inc = (hh_q == HR_MAX) ? 5'd0 : hh_q + 5'd1;
            end
        end
    end

    // Edge counting, set handling and time update; a valid load wins over a second elapsing.
    always_comb begin
        set_valid  = set_en && (set_hh <= HR_MAX) && (set_mm <= MIN_MAX);
        sec_elapse = edge_p && (cnt_q == CNT_LAST) && !set_valid;
        set_err_d  = set_en && !set_valid;
        sec_tick_d = sec_elapse;
        cnt_d      = cnt_q;
        hh_d       = hh_q;
        mm_d       = mm_q;
        ss_d       = ss_q;
        if (set_valid) begin
            cnt_d = '0;
            hh_d  = set_hh;
            mm_d  = set_mm;
            ss_d  = 6'd0;
        end else begin
            if (edge_p) begin
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            end
            if (sec_elapse) begin
                hh_d = hh_inc;
                mm_d = mm_inc;
                ss_d = ss_inc;
            end
        end
        match = sec_elapse && alarm_en && (ss_inc == 6'd0) &&
                (mm_inc == alarm_mm) && (hh_inc == alarm_hh);
    end

    // Alarm state transitions: start on a match, leave on stop, disarm or ring timeout.
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        case (state_q)
            IDLE: begin
                if (match && !stop) begin
                    state_d    = RINGING;
                    ring_cnt_d = '0;
                end
            end
            RINGING: begin
                if (stop || !alarm_en) begin
                    state_d = IDLE;
                end else if (sec_elapse) begin
                    if (ring_cnt_q == RING_LAST) begin
                        state_d = IDLE;
                    end else begin
                        ring_cnt_d = ring_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All timekeeping and alarm registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            hh_q       <= 5'd0;
            mm_q       <= 6'd0;
            ss_q       <= 6'd0;
            sec_tick_q <= 1'b0;
            set_err_q  <= 1'b0;
            ring_cnt_q <= '0;
            state_q    <= IDLE;
        end else begin
            cnt_q      <= cnt_d;
            hh_q       <= hh_d;
            mm_q       <= mm_d;
            ss_q       <= ss_d;
            sec_tick_q <= sec_tick_d;
            set_err_q  <= set_err_d;
            ring_cnt_q <= ring_cnt_d;
            state_q    <= state_d;
        end
    end

    assign hh       = hh_q;
    assign mm       = mm_q;
    assign ss       = ss_q;
    assign sec_tick = sec_tick_q;
    assign set_err  = set_err_q;
    assign ringing  = (state_q == RINGING);

endmodule
